// File: rtl/uart_wb_arb.sv
// Round-robin arbiter sharing one Wishbone master port between two requesters.
// Each grant covers a single transaction. A slave that never answers is cut off by a bus timeout.
module uart_wb_arb #(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned BEW      = 4,
   parameter int unsigned TOUT_CYC = 1024,
   parameter int unsigned CW       = 11
) (
   input  logic           app_clk,
   input  logic           arst,
   input  logic           m0_stb_i,
   input  logic [AW-1:0]  m0_adr_i,
   input  logic           m0_we_i,
   input  logic [DW-1:0]  m0_dat_i,
   input  logic [BEW-1:0] m0_sel_i,
   output logic [DW-1:0]  m0_dat_o,
   output logic           m0_ack_o,
   output logic           m0_err_o,
   input  logic           m1_stb_i,
   input  logic [AW-1:0]  m1_adr_i,
   input  logic           m1_we_i,
   input  logic [DW-1:0]  m1_dat_i,
   input  logic [BEW-1:0] m1_sel_i,
   output logic [DW-1:0]  m1_dat_o,
   output logic           m1_ack_o,
   output logic           m1_err_o,
   output logic           s_cyc_o,
   output logic           s_stb_o,
   output logic [AW-1:0]  s_adr_o,
   output logic           s_we_o,
   output logic [DW-1:0]  s_dat_o,
   output logic [BEW-1:0] s_sel_o,
   input  logic [DW-1:0]  s_dat_i,
   input  logic           s_ack_i,
   input  logic           s_err_i,
   input  logic           tout_clr,
   output logic           busy,
   output logic           cur_gnt,
   output logic           tout_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic          TOUT_EN   = (TOUT_CYC != 32'd0);
   localparam logic [CW-1:0] TOUT_LAST = CW'(TOUT_CYC - 32'd1);

   state_e        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          last_gnt_q, last_gnt_d;
   logic [CW-1:0] tout_cnt_q, tout_cnt_d;
   logic          tout_err_q, tout_err_d;

   logic          gnt_stb;
   logic          tout_hit;
   logic          stb_out;
   logic          resp_ack;
   logic          resp_err;

   always_ff @(posedge app_clk or posedge arst) begin
      if (arst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 1'b0;
         last_gnt_q <= 1'b1;
         tout_cnt_q <= '0;
         tout_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
         tout_cnt_q <= tout_cnt_d;
         tout_err_q <= tout_err_d;
      end
   end

   // Payload follows the registered grant only, never the live strobes.
   assign gnt_stb  = gnt_q ? m1_stb_i : m0_stb_i;
   assign tout_hit = TOUT_EN && (state_q == ST_BUSY) && gnt_stb &&
                     (tout_cnt_q == TOUT_LAST) && !s_ack_i && !s_err_i;

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      tout_cnt_d = tout_cnt_q;
      tout_err_d = tout_err_q;
      stb_out    = 1'b0;
      resp_ack   = 1'b0;
      resp_err   = 1'b0;
      if (tout_clr) begin
         tout_err_d = 1'b0;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (m0_stb_i || m1_stb_i) begin
               state_d    = ST_BUSY;
               tout_cnt_d = '0;
               gnt_d      = (m0_stb_i && m1_stb_i) ? ~last_gnt_q : m1_stb_i;
            end
         end
         ST_BUSY: begin
            stb_out = gnt_stb && !tout_hit;
            if (s_ack_i || s_err_i) begin
               resp_err   = s_err_i;
               resp_ack   = !s_err_i;
               last_gnt_d = gnt_q;
               state_d    = ST_DONE;
            end else if (!gnt_stb) begin
               last_gnt_d = gnt_q;
               state_d    = ST_DONE;
            end else if (tout_hit) begin
               resp_err   = 1'b1;
               tout_err_d = 1'b1;
               last_gnt_d = gnt_q;
               state_d    = ST_DONE;
            end else if (tout_cnt_q != {CW{1'b1}}) begin
               tout_cnt_d = tout_cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign s_stb_o  = stb_out;
   assign s_cyc_o  = stb_out;
   assign s_adr_o  = gnt_q ? m1_adr_i : m0_adr_i;
   assign s_we_o   = gnt_q ? m1_we_i  : m0_we_i;
   assign s_dat_o  = gnt_q ? m1_dat_i : m0_dat_i;
   assign s_sel_o  = gnt_q ? m1_sel_i : m0_sel_i;

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = resp_ack && !gnt_q;
   assign m1_ack_o = resp_ack &&  gnt_q;
   assign m0_err_o = resp_err && !gnt_q;
   assign m1_err_o = resp_err &&  gnt_q;

   assign busy     = (state_q != ST_IDLE);
   assign cur_gnt  = gnt_q;
   assign tout_err = tout_err_q;

endmodule

// File: tb/tb_uart_wb_arb.sv
// Scenario bench for uart_wb_arb: directed cases plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_uart_wb_arb;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned BEW = 4;
   localparam int unsigned TO  = 16;

   logic           app_clk = 1'b0;
   logic           arst;
   logic           m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
   logic [AW-1:0]  m0_adr_i, m1_adr_i;
   logic [DW-1:0]  m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
   logic [BEW-1:0] m0_sel_i, m1_sel_i;
   logic           m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic           s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]  s_adr_o;
   logic [DW-1:0]  s_dat_o, s_dat_i;
   logic [BEW-1:0] s_sel_o;
   logic           s_ack_i, s_err_i, tout_clr;
   logic           busy, cur_gnt, tout_err;

   int checks = 0;
   int errors = 0;
   logic model_last;

   uart_wb_arb #(.AW(AW), .DW(DW), .BEW(BEW), .TOUT_CYC(TO), .CW(5)) dut (
      .app_clk(app_clk), .arst(arst),
      .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i),
      .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i),
      .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
      .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i), .tout_clr(tout_clr), .busy(busy), .cur_gnt(cur_gnt),
      .tout_err(tout_err)
   );

   always #5 app_clk = ~app_clk;

   task automatic step();
      @(posedge app_clk);
      #1;
   endtask

   task automatic do_reset();
      arst = 1'b1;
      {m0_stb_i, m0_we_i, m1_stb_i, m1_we_i} = '0;
      m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
      m0_sel_i = '0; m1_sel_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; tout_clr = 1'b0;
      step();
      step();
      arst = 1'b0;
      model_last = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_stb got %b/%b exp 0/0", s_stb_o, s_cyc_o); end
      checks++; if (cur_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0", cur_gnt); end
      checks++; if (tout_err !== 1'b0) begin errors++; $display("FAIL reset_tout got %b exp 0", tout_err); end
      checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin errors++; $display("FAIL reset_resp got %b exp 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
   endtask

   task automatic test_read();
      m0_stb_i = 1'b1; m0_adr_i = 32'h3000_0004; m0_we_i = 1'b0; m0_sel_i = 4'hF;
      #1;
      checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL read_lat0 got %b exp 0", s_stb_o); end
      step();
      checks++; if (s_stb_o !== 1'b1 || s_adr_o !== 32'h3000_0004 || s_we_o !== 1'b0) begin errors++; $display("FAIL read_stb got %b %h %b exp 1 30000004 0", s_stb_o, s_adr_o, s_we_o); end
      step();
      checks++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL read_early_ack got %b exp 0", m0_ack_o); end
      step();
      s_ack_i = 1'b1; s_dat_i = 32'hA5A5_1234;
      #1;
      checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hA5A5_1234 || m1_ack_o !== 1'b0) begin errors++; $display("FAIL read_ack got %b %h %b exp 1 a5a51234 0", m0_ack_o, m0_dat_o, m1_ack_o); end
      step();
      s_ack_i = 1'b0; m0_stb_i = 1'b0;
      #1;
      checks++; if (busy !== 1'b1 || s_stb_o !== 1'b0) begin errors++; $display("FAIL read_done got %b %b exp 1 0", busy, s_stb_o); end
      step();
      model_last = 1'b0;
   endtask

   task automatic test_fairness();
      do_reset();
      m0_stb_i = 1'b1; m1_stb_i = 1'b1; m0_adr_i = 32'h100; m1_adr_i = 32'h200;
      for (int k = 0; k < 12; k++) begin
         s_ack_i = 1'b0;
         #1;
         s_ack_i = s_stb_o;
         #1;
         checks++; if (busy !== (k % 3 != 0)) begin errors++; $display("FAIL fair_busy k=%0d got %b exp %b", k, busy, (k % 3 != 0)); end
         if (k % 3 == 1) begin
            checks++; if (cur_gnt !== 1'((k / 3) % 2) || m0_ack_o !== ((k / 3) % 2 == 0) || m1_ack_o !== ((k / 3) % 2 == 1)) begin
               errors++; $display("FAIL fair_gnt k=%0d got %b %b%b exp %0d", k, cur_gnt, m0_ack_o, m1_ack_o, (k / 3) % 2);
            end
         end
         step();
      end
      m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
      model_last = 1'b1;
      step();
   endtask

   task automatic test_timeout();
      for (int r = 0; r < 2; r++) begin
         m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h40; m1_dat_i = 32'hDEAD_BEEF;
         tout_clr = (r == 1);
         step();
         for (int c = 1; c <= int'(TO); c++) begin
            #1;
            checks++; if (s_stb_o !== (c != int'(TO)) || m1_err_o !== (c == int'(TO)) || m0_err_o !== 1'b0) begin
               errors++; $display("FAIL tout_cyc r=%0d c=%0d got stb %b err %b exp stb %b err %b", r, c, s_stb_o, m1_err_o, c != int'(TO), c == int'(TO));
            end
            if (c < int'(TO)) step();
         end
         step();
         m1_stb_i = 1'b0; tout_clr = 1'b0;
         #1;
         checks++; if (tout_err !== 1'b1) begin errors++; $display("FAIL tout_set r=%0d got %b exp 1", r, tout_err); end
         step();
         tout_clr = 1'b1;
         step();
         tout_clr = 1'b0;
         #1;
         checks++; if (tout_err !== 1'b0) begin errors++; $display("FAIL tout_clr r=%0d got %b exp 0", r, tout_err); end
      end
      model_last = 1'b1;
   endtask

   task automatic test_err_prec();
      m0_stb_i = 1'b1; m0_adr_i = 32'h80;
      step();
      s_ack_i = 1'b1; s_err_i = 1'b1;
      #1;
      checks++; if (m0_err_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin errors++; $display("FAIL err_prec got err %b ack %b exp 1 0", m0_err_o, m0_ack_o); end
      step();
      s_ack_i = 1'b0; s_err_i = 1'b0; m0_stb_i = 1'b0;
      step();
      model_last = 1'b0;
   endtask

   task automatic test_abort();
      do_reset();
      m0_stb_i = 1'b1; m1_stb_i = 1'b1; m0_adr_i = 32'h11; m1_adr_i = 32'h22;
      step();
      checks++; if (cur_gnt !== 1'b0) begin errors++; $display("FAIL abort_gnt0 got %b exp 0", cur_gnt); end
      m0_stb_i = 1'b0;
      #1;
      checks++; if (s_stb_o !== 1'b0 || {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin errors++; $display("FAIL abort_drop got %b %b exp 0 0000", s_stb_o, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
      step();
      checks++; if (busy !== 1'b1 || s_stb_o !== 1'b0) begin errors++; $display("FAIL abort_done got %b %b exp 1 0", busy, s_stb_o); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b exp 0", busy); end
      step();
      checks++; if (cur_gnt !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== 32'h22) begin errors++; $display("FAIL abort_m1 got %b %b %h exp 1 1 22", cur_gnt, s_stb_o, s_adr_o); end
      s_ack_i = 1'b1;
      #1;
      checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin errors++; $display("FAIL abort_m1ack got %b %b exp 1 0", m1_ack_o, m0_ack_o); end
      step();
      s_ack_i = 1'b0; m1_stb_i = 1'b0;
      step();
      model_last = 1'b1;
   endtask

   task automatic test_random();
      logic [AW-1:0] a0, a1, ea;
      logic [DW-1:0] d0, d1, ed, rd;
      logic [BEW-1:0] e0, e1, es;
      logic w0, w1, ew, eg;
      int pat, lat, kind;
      for (int it = 0; it < 40; it++) begin
         pat = int'($urandom_range(1, 3)); lat = int'($urandom_range(0, 3)); kind = int'($urandom_range(0, 3));
         a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom; rd = $urandom;
         e0 = BEW'($urandom); e1 = BEW'($urandom); w0 = 1'($urandom); w1 = 1'($urandom);
         eg = (pat == 3) ? ~model_last : (pat == 2);
         ea = eg ? a1 : a0; ed = eg ? d1 : d0; es = eg ? e1 : e0; ew = eg ? w1 : w0;
         m0_adr_i = a0; m1_adr_i = a1; m0_dat_i = d0; m1_dat_i = d1;
         m0_sel_i = e0; m1_sel_i = e1; m0_we_i = w0; m1_we_i = w1;
         m0_stb_i = pat[0]; m1_stb_i = pat[1];
         #1;
         checks++; if (busy !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL rnd_idle it=%0d got %b %b exp 0 0", it, busy, s_stb_o); end
         step();
         checks++; if (cur_gnt !== eg || s_stb_o !== 1'b1 || s_adr_o !== ea || s_dat_o !== ed || s_sel_o !== es || s_we_o !== ew) begin
            errors++; $display("FAIL rnd_bus it=%0d got g%b s%b %h %h %h %b exp g%b s1 %h %h %h %b", it, cur_gnt, s_stb_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, eg, ea, ed, es, ew);
         end
         for (int l = 0; l < lat; l++) begin
            checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin errors++; $display("FAIL rnd_wait it=%0d got %b exp 0000", it, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
            step();
         end
         s_dat_i = rd; s_ack_i = (kind != 2); s_err_i = (kind >= 2);
         #1;
         checks++; if (m0_ack_o !== (!eg && kind < 2) || m1_ack_o !== (eg && kind < 2) || m0_err_o !== (!eg && kind >= 2) || m1_err_o !== (eg && kind >= 2) || m0_dat_o !== rd || m1_dat_o !== rd) begin
            errors++; $display("FAIL rnd_resp it=%0d got a%b%b e%b%b exp g%b kind %0d", it, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, eg, kind);
         end
         step();
         s_ack_i = 1'b0; s_err_i = 1'b0; m0_stb_i = 1'b0; m1_stb_i = 1'b0;
         #1;
         checks++; if (busy !== 1'b1 || s_stb_o !== 1'b0) begin errors++; $display("FAIL rnd_done it=%0d got %b %b exp 1 0", it, busy, s_stb_o); end
         step();
         model_last = eg;
      end
   endtask

   task automatic test_reset_mid();
      m0_stb_i = 1'b1; m0_adr_i = 32'h55;
      step();
      #1;
      checks++; if (s_stb_o !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", s_stb_o); end
      #2;
      arst = 1'b1; s_ack_i = 1'b1;
      #1;
      checks++; if (s_stb_o !== 1'b0 || busy !== 1'b0 || m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin errors++; $display("FAIL mid_async got %b %b %b %b exp 0 0 0 0", s_stb_o, busy, m0_ack_o, m0_err_o); end
      step();
      arst = 1'b0; s_ack_i = 1'b0; m1_stb_i = 1'b1; model_last = 1'b1;
      step();
      checks++; if (cur_gnt !== ~model_last || s_stb_o !== 1'b1) begin errors++; $display("FAIL mid_regrant got %b %b exp 0 1", cur_gnt, s_stb_o); end
      s_ack_i = 1'b1;
      step();
      s_ack_i = 1'b0; m0_stb_i = 1'b0; m1_stb_i = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_read();
      test_fairness();
      test_timeout();
      test_err_prec();
      test_abort();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_wb_arb.md
Name: uart_wb_arb

Overview:
Two-requester Wishbone master arbiter for the app_clk domain. It shares one Wishbone master port between the UART-to-WB bridge (requester 0) and a second host bridge (requester 1), using round-robin selection. Each grant is held for a single transaction, a hung slave is caught by a bus timeout, and timeout status is reported. It sits between the bridges' wbm_* outputs and the chip's Wishbone interconnect.

Parameters:
AW, 32, address width
DW, 32, data width
BEW, 4, byte-enable width
TOUT_CYC, 1024, cycles in BUSY before a forced error; 0 disables the timeout
CW, 11, timeout counter width; must be ≥ clog2(TOUT_CYC+1)

Ports:
app_clk  in  1  system clock
arst  in  1  asynchronous active-high reset
m0_stb_i  in  1  requester 0 strobe (cyc equals stb)
m0_adr_i  in  AW  requester 0 address
m0_we_i  in  1  requester 0 write
m0_dat_i  in  DW  requester 0 write data
m0_sel_i  in  BEW  requester 0 byte enable
m0_dat_o  out  DW  requester 0 read data
m0_ack_o  out  1  requester 0 ack
m0_err_o  out  1  requester 0 error
m1_*  same set as m0_*, for requester 1
s_cyc_o  out  1  slave cycle (equals s_stb_o)
s_stb_o  out  1  slave strobe
s_adr_o  out  AW  slave address
s_we_o  out  1  slave write
s_dat_o  out  DW  slave write data
s_sel_o  out  BEW  slave byte enable
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
tout_clr  in  1  clears tout_err
busy  out  1  state != IDLE
cur_gnt  out  1  current/last grant index
tout_err  out  1  sticky timeout flag

Behaviour:
- Reset (arst=1, asynchronous): state=IDLE, gnt=0, last_gnt=1 (requester 0 wins the first tie), tout_cnt=0, tout_err=0.
- Reset values of outputs: s_stb_o=0, s_cyc_o=0, all m*_ack_o=0, all m*_err_o=0, busy=0. Data/address outputs follow the mux with gnt=0.
- Reset mid-transaction aborts immediately. No ack or err is returned to either requester.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Only m0_stb_i set: gnt<=0. Only m1_stb_i set: gnt<=1.
  - Both set: gnt <= ~last_gnt.
  - Any request moves to BUSY and clears tout_cnt.
  - Latency: a request seen at cycle N drives s_stb_o at N+1.
- BUSY:
  - s_stb_o = m[gnt]_stb_i.
  - s_adr_o/we/dat/sel are muxed by gnt (registered gnt only, no comb path from stb).
  - s_ack_i or s_err_i: forwarded combinationally the same cycle to m[gnt]_ack_o/err_o; last_gnt<=gnt; next state DONE.
  - Both s_ack_i and s_err_i set in the same cycle: err wins and ack is suppressed.
  - Granted requester drops stb without a response (abort): last_gnt<=gnt; go to DONE with no response.
  - Timeout, when TOUT_CYC != 0 and tout_cnt == TOUT_CYC-1 with no ack/err:
    - s_stb_o forced 0 in that cycle.
    - m[gnt]_err_o=1 for one cycle.
    - tout_err<=1, last_gnt<=gnt, go to DONE.
  - Otherwise tout_cnt increments by 1. It saturates and never wraps.
- DONE: one cycle with no grant and s_stb_o=0. This lets the requester deassert its registered stb, so no stale re-grant occurs. Then go to IDLE.
- Non-granted requester: ack/err held 0. mX_dat_o = s_dat_i for both requesters.
- A response (ack/err) is never given to the non-granted requester. At most one ack or err per granted transaction.
- Minimum spacing: back-to-back transactions from one requester take 3 cycles (IDLE, BUSY with ack, DONE).
- tout_err:
  - Set on timeout.
  - Cleared by tout_clr.
  - If set and clear occur in the same cycle, set wins.
- cur_gnt = gnt. busy = (state != IDLE).

Test Plan:
- Read, single requester: m0 read at 0x3000_0004; slave acks 2 cycles after s_stb with 0xA5A5_1234 → s_stb rises 1 cycle after m0_stb; m0_ack_o=1 with m0_dat_o=0xA5A5_1234; m1_ack_o stays 0.
- Fairness: m0 and m1 both request continuously for 4 transactions, slave acks in 1 cycle → grant order 0,1,0,1; each transaction occupies exactly 3 cycles.
- Timeout: TOUT_CYC=16; m1 write, slave never acks → m1_err_o pulses at the 16th BUSY cycle; s_stb drops that cycle; tout_err=1 until a tout_clr pulse, after which it reads 0.
- Error precedence: s_ack_i and s_err_i asserted together → m0_err_o=1, m0_ack_o=0.
- Abort: m0 drops stb in BUSY with no response → DONE then IDLE; a pending m1 is granted next.
- Reset mid-operation: assert arst during BUSY → s_stb_o=0, busy=0 immediately (asynchronously); after release, simultaneous requests grant m0 first.
